load_sequencer: RTL and testbench
=================================

Name: load_sequencer

Overview:
- Multi-cycle load controller between the control unit and word-wide data memory.
- Accepts one load request at a time and issues a word-aligned memory read.
- Waits a fixed memory latency, captures the word, then extracts and zero-extends the word, halfword or byte selected by size and address offset.
- Returns the result on a valid/ready response channel for the register-file write mux.
- Detects misaligned or invalid requests without touching memory.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_rd pulse to mem_rdata valid; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold MEM_LATENCY.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_addr  input  32  byte address of the load.
- req_size  input  2  00 word, 01 half, 10 byte, 11 invalid.
- req_signed  input  1  sign-extend request; honoured only with the optional feature.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  extracted load data.
- rsp_err  output  1  misaligned or invalid request; qualified by rsp_valid.
- mem_rd  output  1  one-cycle memory read strobe.
- mem_addr  output  32  {req_addr[31:2],2'b00}; held stable from ISSUE through CAPTURE.
- mem_rdata  input  32  memory read data.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, highest priority, legal in any state, including mid-transaction):
  - State goes to IDLE; the latency counter clears.
  - rsp_valid, rsp_err, mem_rd and busy go to 0; rsp_data and mem_addr go to 0.
  - req_ready is 1 from the first cycle after reset.
  - Any in-flight memory data is discarded; mem_rd is never reissued for the aborted request.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - req_ready=1. On req_valid, latch addr, size and signed.
  - Alignment check on the latched request:
    - size 11 -> error.
    - size 00 with addr[1:0]!=0 -> error.
    - size 01 with addr[0]!=0 -> error.
  - On error: go to DONE with rsp_err=1 and rsp_data=0. No mem_rd is issued.
  - Otherwise go to ISSUE.
- ISSUE: mem_rd=1 for exactly this cycle. Load the counter with MEM_LATENCY-1. Go to WAIT if MEM_LATENCY>1, else CAPTURE.
- WAIT: decrement the counter each cycle; go to CAPTURE when the counter reaches 1.
- CAPTURE:
  - Reached exactly MEM_LATENCY cycles after the ISSUE cycle.
  - Sample mem_rdata, extract the result (little-endian lanes), register it into rsp_data, and go to DONE.
  - Word: data.
  - Half: addr[1]=0 -> data[15:0]; addr[1]=1 -> data[31:16]. Zero-extended.
  - Byte: lane addr[1:0] selects data[8k+7:8k]. Zero-extended.
- DONE:
  - rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready.
  - When rsp_valid && rsp_ready, go to IDLE in the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake; there is no back-to-back overlap.
- Latency: accept at edge 0. mem_rd is high in cycle 1. rsp_valid first rises in cycle MEM_LATENCY+2. Error path: rsp_valid in cycle 1.
- Request inputs are ignored outside IDLE. Inputs do not need to stay stable after acceptance.
- rsp_ready held high before DONE has no effect.

Optional Feature:
- Macro: LOAD_SIGN_EXT_EN.
- Defined: when req_signed=1, half and byte results are sign-extended from bit 15 or bit 7 of the extracted field. Word results are unaffected.
- Undefined: req_signed is ignored, all results are zero-extended, and no sign-extension logic is synthesised.

Test Plan:
- Reset then idle: hold reset 2 cycles -> all outputs 0; req_ready=1 and busy=0 on the first cycle after reset.
- Word load, MEM_LATENCY=1, addr 0x100, mem_rdata 0xDEADBEEF:
  - mem_rd one cycle with mem_addr 0x100.
  - rsp_valid in cycle 3 with rsp_data 0xDEADBEEF and rsp_err=0.
- Sub-word lanes, MEM_LATENCY=3, mem_rdata 0x8899AABB:
  - Byte at addr 0x202 -> 0x00000099.
  - Half at addr 0x202 -> 0x00008899.
  - Check mem_addr 0x200 and rsp_valid in cycle 5.
- Misalignment and invalid size:
  - Word at 0x101 -> rsp_valid in cycle 1, rsp_err=1, rsp_data=0, mem_rd never asserted.
  - Same result for half at 0x103 and for size 11.
- Backpressure and reset abort:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable; a req_valid during this time is not accepted.
  - Assert reset during WAIT -> IDLE next cycle, no rsp_valid, no second mem_rd.
- With LOAD_SIGN_EXT_EN defined, mem_rdata 0x0000F080:
  - Signed byte at addr 0x0 -> 0xFFFFFF80.
  - Signed half at addr 0x0 -> 0xFFFFF080.
  - Unsigned byte -> 0x00000080.
  - Without the macro, the signed byte returns 0x00000080.

Source files
------------

// File: rtl/load_sequencer.sv
// load_sequencer: multi-cycle load controller issuing word reads, extracting word/half/byte results; ports: clk, reset, req_* (request in), rsp_* (result out), mem_* (memory read), busy; optional macro LOAD_SIGN_EXT_EN enables sign extension
module load_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0] lane, size;
  logic bad;
  logic [15:0] half;
  logic [7:0] b8;
  logic [31:0] ext;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  assign mem_rd = state == ISSUE;
  assign bad = req_size == 2'b11 || (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
               (req_size == 2'b01 && req_addr[0]);
  assign half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign b8 = mem_rdata[{lane, 3'b000} +: 8];
`ifdef LOAD_SIGN_EXT_EN
  logic sgn;
  assign ext = size == 2'b00 ? mem_rdata :
               size == 2'b01 ? {{16{sgn & half[15]}}, half} : {{24{sgn & b8[7]}}, b8};
  always_ff @(posedge clk)
    if (reset) sgn <= 1'b0;
    else if (state == IDLE && req_valid) sgn <= req_signed;
`else
  logic unused_signed;
  assign unused_signed = req_signed;
  assign ext = size == 2'b00 ? mem_rdata : size == 2'b01 ? {16'h0, half} : {24'h0, b8};
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (bad ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nx = MEM_LATENCY > 1 ? WAIT : CAPTURE;
      WAIT:    state_nx = cnt == CNT_W'(1) ? CAPTURE : WAIT;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      lane <= 2'b00;
      size <= 2'b00;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        lane <= req_addr[1:0];
        size <= req_size;
        rsp_err <= bad;
        rsp_data <= '0;
        if (!bad) mem_addr <= {req_addr[31:2], 2'b00};
      end
      if (state == ISSUE) cnt <= CNT_W'(MEM_LATENCY - 1);
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == CAPTURE) rsp_data <= ext;
    end
  end
endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed self-checking bench driving latency-1 and latency-3 instances in parallel
module tb_load_sequencer;
  logic clk, reset, req_valid, req_signed, rsp_ready;
  logic [31:0] req_addr, mem_word;
  logic [1:0] req_size;
  logic req_ready1, rsp_valid1, rsp_err1, mem_rd1, busy1;
  logic req_ready3, rsp_valid3, rsp_err3, mem_rd3, busy3;
  logic [31:0] rsp_data1, mem_addr1, rsp_data3, mem_addr3;
  int checks = 0, errors = 0;
  load_sequencer #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(mem_word), .busy(busy1));
  load_sequencer #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
    .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(mem_word), .busy(busy3));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [1:0] s, input logic sg,
                     input logic [31:0] w, input logic [31:0] exp_d, input logic e);
    int v1 = 0, v3 = 0, r1 = 0, r3 = 0, rc1 = 0, rc3 = 0;
    logic [31:0] d1 = '0, d3 = '0, ma1 = '0, ma3 = '0;
    logic e1 = 1'b0, e3 = 1'b0;
    mem_word = w;
    @(negedge clk);
    check({tag, "_rdy"}, {req_ready1, req_ready3}, 2'b11);
    req_valid = 1'b1;
    req_addr = a;
    req_size = s;
    req_signed = sg;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_rd1) begin rc1++; r1 = c; ma1 = mem_addr1; end
      if (mem_rd3) begin rc3++; r3 = c; ma3 = mem_addr3; end
      if (rsp_valid1 && v1 == 0) begin v1 = c; d1 = rsp_data1; e1 = rsp_err1; end
      if (rsp_valid3 && v3 == 0) begin v3 = c; d3 = rsp_data3; e3 = rsp_err3; end
    end
    check({tag, "_vcyc1"}, v1, e ? 1 : 3);
    check({tag, "_vcyc3"}, v3, e ? 1 : 5);
    check({tag, "_data1"}, d1, exp_d);
    check({tag, "_data3"}, d3, exp_d);
    check({tag, "_err"}, {e1, e3}, {e, e});
    check({tag, "_rdcnt"}, {rc1[3:0], rc3[3:0]}, e ? 8'h00 : 8'h11);
    if (!e) begin
      check({tag, "_rdcyc"}, {r1[3:0], r3[3:0]}, 8'h11);
      check({tag, "_maddr1"}, ma1, a & 32'hFFFF_FFFC);
      check({tag, "_maddr3"}, ma3, a & 32'hFFFF_FFFC);
    end
  endtask
  initial begin
    int hits;
    logic [31:0] held;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_signed = 1'b0;
    rsp_ready = 1'b1;
    mem_word = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ctl1", {rsp_valid1, rsp_err1, mem_rd1, busy1, req_ready1}, 5'b00001);
    check("rst_ctl3", {rsp_valid3, rsp_err3, mem_rd3, busy3, req_ready3}, 5'b00001);
    check("rst_data", rsp_data1 | rsp_data3, 32'h0);
    check("rst_maddr", mem_addr1 | mem_addr3, 32'h0);
    run("word", 32'h100, 2'b00, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    run("byte202", 32'h202, 2'b10, 1'b0, 32'h8899AABB, 32'h00000099, 1'b0);
    run("half202", 32'h202, 2'b01, 1'b0, 32'h8899AABB, 32'h00008899, 1'b0);
    run("byte201", 32'h201, 2'b10, 1'b0, 32'h8899AABB, 32'h000000AA, 1'b0);
    run("half200", 32'h200, 2'b01, 1'b0, 32'h8899AABB, 32'h0000AABB, 1'b0);
    run("mis_word", 32'h101, 2'b00, 1'b0, 32'h8899AABB, 32'h0, 1'b1);
    run("mis_half", 32'h103, 2'b01, 1'b0, 32'h8899AABB, 32'h0, 1'b1);
    run("bad_size", 32'h100, 2'b11, 1'b0, 32'h8899AABB, 32'h0, 1'b1);
`ifdef LOAD_SIGN_EXT_EN
    run("sbyte", 32'h0, 2'b10, 1'b1, 32'h0000F080, 32'hFFFFFF80, 1'b0);
    run("shalf", 32'h0, 2'b01, 1'b1, 32'h0000F080, 32'hFFFFF080, 1'b0);
`else
    run("sbyte", 32'h0, 2'b10, 1'b1, 32'h0000F080, 32'h00000080, 1'b0);
    run("shalf", 32'h0, 2'b01, 1'b1, 32'h0000F080, 32'h0000F080, 1'b0);
`endif
    run("ubyte", 32'h0, 2'b10, 1'b0, 32'h0000F080, 32'h00000080, 1'b0);
    run("sword", 32'h0, 2'b00, 1'b1, 32'h0000F080, 32'h0000F080, 1'b0);
    mem_word = 32'h12345678;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h400;
    req_size = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_valid", rsp_valid3, 1'b1);
    check("bp_data", rsp_data3, 32'h12345678);
    held = rsp_data3;
    mem_word = 32'hCAFEF00D;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 req_valid = 1'b1;
      req_addr = 32'h300;
      @(negedge clk);
      if (!rsp_valid3 || rsp_data3 !== held || req_ready3 || !busy3 || mem_rd3) hits++;
    end
    check("bp_stable", hits, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {rsp_valid3, req_ready3, busy3}, 3'b010);
    check("bp_norsp", {rsp_valid1, busy1}, 2'b00);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h500;
    req_size = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ab_wait", {busy3, mem_rd3}, 2'b10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ab_idle", {req_ready3, busy3, rsp_valid3, mem_rd3}, 4'b1000);
    check("ab_data", rsp_data3, 32'h0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid1 || rsp_valid3 || mem_rd1 || mem_rd3) hits++;
    end
    check("ab_quiet", hits, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
